imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (16-bit word count, big-endian
// 32-bit words, XOR checksum byte), writes the words into instruction RAM
// and holds the CPU in reset until a complete image with a good checksum
// has been loaded.
//
// Handshake: a byte moves from the source when in_valid && in_ready are both
// high at a rising clk edge. in_ready depends only on the current state, and
// the source may hold or drop in_valid freely; nothing advances without it.
module imem_loader #(
   parameter int MEM_DEPTH = 256,
   parameter int AW        = $clog2(MEM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          start,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          cpu_reset,
   output logic          done,
   output logic          error,
   output logic [15:0]   words_loaded,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR_HI = 3'd1,
      S_HDR_LO = 3'd2,
      S_DATA   = 3'd3,
      S_CSUM   = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

   state_t      state_q, state_d;
   logic [7:0]  count_hi_q;
   logic [15:0] count_q;
   logic [23:0] asm_q;
   logic [1:0]  byte_cnt_q;
   logic [7:0]  csum_q;
   logic [15:0] wl_q;

   logic        xfer;
   logic [15:0] hdr_count;
   logic        last_word;
   logic        enter_hdr;
   logic        word_done;

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      xfer      = 1'b0;
      hdr_count = {count_hi_q, in_data};
      last_word = ((wl_q + 16'd1) == count_q);
      case (state_q)
         S_IDLE:   state_d = S_HDR_HI;
         S_HDR_HI: begin
            in_ready = 1'b1;
            xfer     = in_valid;
            if (in_valid) state_d = S_HDR_LO;
         end
         S_HDR_LO: begin
            in_ready = 1'b1;
            xfer     = in_valid;
            if (in_valid) begin
               if (hdr_count == 16'd0)                state_d = S_CSUM;
               else if ({1'b0, hdr_count} > DEPTH_L) state_d = S_ERR;
               else                                   state_d = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            xfer     = in_valid;
            // Last byte of the final word hands over to the checksum byte.
            if (in_valid && (byte_cnt_q == 2'd3) && last_word) state_d = S_CSUM;
         end
         S_CSUM: begin
            in_ready = 1'b1;
            xfer     = in_valid;
            if (in_valid) state_d = (csum_q == in_data) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
            if (start) state_d = S_HDR_HI;
         end
         default: state_d = S_IDLE;
      endcase
      enter_hdr = (state_d == S_HDR_HI) && (state_q != S_HDR_HI);
      word_done = (state_q == S_DATA) && xfer && (byte_cnt_q == 2'd3);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Header capture, word assembly, checksum and RAM write strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_hi_q <= 8'd0;
         count_q    <= 16'd0;
         asm_q      <= 24'd0;
         byte_cnt_q <= 2'd0;
         csum_q     <= 8'd0;
         wl_q       <= 16'd0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (enter_hdr) begin
            wl_q       <= 16'd0;
            csum_q     <= 8'd0;
            byte_cnt_q <= 2'd0;
         end
         if ((state_q == S_HDR_HI) && xfer) count_hi_q <= in_data;
         if ((state_q == S_HDR_LO) && xfer) count_q    <= hdr_count;
         if ((state_q == S_DATA) && xfer) begin
            csum_q     <= csum_q ^ in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            asm_q      <= {asm_q[15:0], in_data};
         end
         // Address is the pre-increment count, so word k lands at address k.
         if (word_done) begin
            mem_we    <= 1'b1;
            mem_wdata <= {asm_q, in_data};
            mem_addr  <= wl_q[AW-1:0];
            wl_q      <= wl_q + 16'd1;
         end
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      cpu_reset    = (state_q != S_DONE);
      done         = (state_q == S_DONE);
      error        = (state_q == S_ERR);
      words_loaded = wl_q;
      dbg_state    = state_q;
   end

endmodule
